univ_shift_reg: RTL and testbench
=================================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; legal range 2..32.
REQ-002 Parameter CW, default $clog2(WIDTH+1), width of bit_cnt.
REQ-003 clk  input  1  clock; all state updates on the falling edge.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 mode  input  3  operation select, sampled each falling edge while IDLE.
REQ-006 par_in  input  WIDTH  parallel load data.
REQ-007 ser_in_l  input  1  serial input entering at the MSB side.
REQ-008 ser_in_r  input  1  serial input entering at the LSB side.
REQ-009 start  input  1  request a WIDTH-bit serial transfer.
REQ-010 q  output  WIDTH  register contents.
REQ-011 ser_out  output  1  serial output, equal to q[0] at all times.
REQ-012 busy  output  1  high while the FSM is in XFER.
REQ-013 done  output  1  one-cycle pulse while the FSM is in DONE.
REQ-014 bit_cnt  output  CW  bits shifted so far in the current transfer.
REQ-015 parity  output  1  even parity of q (see Configuration).

Function
REQ-016 The FSM SHALL have three states: IDLE, XFER and DONE.
REQ-017 IDLE with start=1 SHALL move to XFER on the next falling edge, clear bit_cnt to 0, and leave q unchanged on that edge.
REQ-018 In IDLE with start=0, the register SHALL apply mode on each falling edge:
- 000 hold.
- 001 shift right, with ser_in_l into the MSB.
- 010 shift left, with ser_in_r into the LSB.
- 011 load par_in.
- 100 rotate right.
- 101 rotate left.
- 110 count up, modulo 2^WIDTH.
- 111 count down, modulo 2^WIDTH.
REQ-019 Counting SHALL wrap: all-ones +1 gives 0, and 0 -1 gives all-ones; no carry output.
REQ-020 In XFER, each falling edge SHALL shift q right with ser_in_l into the MSB and increment bit_cnt.
REQ-021 After the WIDTH-th shift (bit_cnt reaches WIDTH), the FSM SHALL move to DONE.
REQ-022 DONE SHALL hold q, assert done for exactly one cycle, then return to IDLE.
REQ-023 mode and start SHALL be ignored in XFER and DONE.
REQ-024 start=1 in IDLE SHALL take priority over mode.
REQ-025 bit_cnt SHALL hold its final value (WIDTH) through DONE and IDLE until the next start.
REQ-026 Outputs SHALL be registered, except ser_out (combinational, q[0]) and parity (REQ-031).

Reset
REQ-027 reset=0 sampled at a falling edge SHALL take priority over all other inputs.
REQ-028 On that edge: q=0, FSM=IDLE, bit_cnt=0, busy=0, done=0.
REQ-029 Reset asserted mid-XFER SHALL abort the transfer with no done pulse.
REQ-030 The block SHALL leave reset on the first falling edge with reset=1 and act on that edge's inputs.

Configuration
REQ-031 With macro USR_PARITY_EN defined, parity SHALL equal the XOR reduction of q, updated combinationally with q.
REQ-032 Without USR_PARITY_EN, parity SHALL be tied to 0 and no parity logic SHALL be present.

Verification (WIDTH=8)
REQ-033 Reset then load: reset=0 for one edge, then mode=011, par_in=8'hA5 -> q=00 after reset, q=A5 after the next edge, parity=0 with macro.
REQ-034 Shift/rotate: from q=8'h81, mode=100 -> q=C0; then mode=101 -> q=81; then mode=010 with ser_in_r=0 -> q=02.
REQ-035 Counter wrap: q=FF, mode=110 -> q=00; then mode=111 -> q=FF.
REQ-036 Serial transfer: q=8'hB4, ser_in_l fed 1,0,1,0,0,1,0,1 (first bit first), start pulsed:
- busy high for 8 edges; ser_out sequence 0,0,1,0,1,1,0,1.
- then q=A5, done high one cycle, bit_cnt=8.
REQ-037 Abort and ignore: start mid-XFER is ignored (no retrigger); reset=0 after 3 shifts -> q=00, busy=0, no done, bit_cnt=0.

Source files
------------

// File: rtl/univ_shift_reg_if.sv
// Signal bundle for univ_shift_reg: mode/data/serial inputs and register status outputs.
// The slave side belongs to the shift register; the master side drives it.
interface univ_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
);
    logic [2:0]       mode;
    logic [WIDTH-1:0] par_in;
    logic             ser_in_l;
    logic             ser_in_r;
    logic             start;
    logic [WIDTH-1:0] q;
    logic             ser_out;
    logic             busy;
    logic             done;
    logic [CW-1:0]    bit_cnt;
    logic             parity;

    modport master (
        output mode, par_in, ser_in_l, ser_in_r, start,
        input  q, ser_out, busy, done, bit_cnt, parity
    );

    modport slave (
        input  mode, par_in, ser_in_l, ser_in_r, start,
        output q, ser_out, busy, done, bit_cnt, parity
    );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register (hold/shift/load/rotate/count) with a WIDTH-bit serial transfer FSM.
// All state changes on the falling clock edge. Optional macro USR_PARITY_EN adds even parity of q.
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    univ_shift_reg_if.slave    sr
);
    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             busy_reg, done_reg;

    always_ff @(negedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            q_reg     <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            q_reg     <= q_next;
            cnt_reg   <= cnt_next;
            // Status flags follow the state being entered so they are true registers.
            busy_reg  <= (state_next == XFER);
            done_reg  <= (state_next == DONE);
        end
    end

    always_comb begin
        state_next = state_reg;
        q_next     = q_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (sr.start) begin
                    state_next = XFER;
                    cnt_next   = '0;
                end else begin
                    case (sr.mode)
                        3'b000: q_next = q_reg;
                        3'b001: q_next = {sr.ser_in_l, q_reg[WIDTH-1:1]};
                        3'b010: q_next = {q_reg[WIDTH-2:0], sr.ser_in_r};
                        3'b011: q_next = sr.par_in;
                        3'b100: q_next = {q_reg[0], q_reg[WIDTH-1:1]};
                        3'b101: q_next = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
                        3'b110: q_next = q_reg + WIDTH'(1);
                        3'b111: q_next = q_reg - WIDTH'(1);
                        default: q_next = q_reg;
                    endcase
                end
            end
            XFER: begin
                q_next   = {sr.ser_in_l, q_reg[WIDTH-1:1]};
                cnt_next = cnt_reg + CW'(1);
                if (cnt_reg == CW'(WIDTH - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign sr.q       = q_reg;
    assign sr.ser_out = q_reg[0];
    assign sr.busy    = busy_reg;
    assign sr.done    = done_reg;
    assign sr.bit_cnt = cnt_reg;

`ifdef USR_PARITY_EN
    assign sr.parity = ^q_reg;
`else
    assign sr.parity = 1'b0;
`endif
endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed scenarios then randomized traffic,
// all compared against an arithmetic reference model of the register and transfer.
module tb_univ_shift_reg;
    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);
    localparam int unsigned MASK = (1 << W) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    univ_shift_reg_if #(.WIDTH(W), .CW(CW)) bus ();

    univ_shift_reg #(.WIDTH(W), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .sr    (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int unsigned m_q    = 0;
    bit          m_busy = 0;
    bit          m_done = 0;
    int          m_cnt  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [2:0] md, input logic [W-1:0] par,
                         input logic sil, input logic sir, input logic st);
        reset        = r;
        bus.mode     = md;
        bus.par_in   = par;
        bus.ser_in_l = sil;
        bus.ser_in_r = sir;
        bus.start    = st;
    endtask

    function automatic void model_edge();
        int unsigned sil = {31'd0, bus.ser_in_l};
        int unsigned sir = {31'd0, bus.ser_in_r};
        if (!reset) begin
            m_q = 0; m_busy = 0; m_done = 0; m_cnt = 0;
        end else if (m_busy) begin
            m_q = (m_q >> 1) | (sil << (W - 1));
            m_cnt++;
            if (m_cnt == W) begin
                m_busy = 0;
                m_done = 1;
            end
        end else if (m_done) begin
            m_done = 0;
        end else if (bus.start) begin
            m_busy = 1;
            m_cnt  = 0;
        end else begin
            case (bus.mode)
                3'd1: m_q = (m_q >> 1) | (sil << (W - 1));
                3'd2: m_q = ((m_q << 1) & MASK) | sir;
                3'd3: m_q = {24'd0, bus.par_in};
                3'd4: m_q = (m_q >> 1) | ((m_q & 1) << (W - 1));
                3'd5: m_q = ((m_q << 1) & MASK) | (m_q >> (W - 1));
                3'd6: m_q = (m_q + 1) & MASK;
                3'd7: m_q = (m_q - 1) & MASK;
                default: m_q = m_q;
            endcase
        end
    endfunction

    task automatic check_all();
        logic [31:0] exp_par;
`ifdef USR_PARITY_EN
        exp_par = {31'd0, ^m_q[W-1:0]};
`else
        exp_par = 32'd0;
`endif
        chk("q",       {24'd0, bus.q},            m_q);
        chk("ser_out", {31'd0, bus.ser_out},      m_q & 1);
        chk("busy",    {31'd0, bus.busy},         {31'd0, m_busy});
        chk("done",    {31'd0, bus.done},         {31'd0, m_done});
        chk("bit_cnt", {{(32-CW){1'b0}}, bus.bit_cnt}, m_cnt);
        chk("parity",  {31'd0, bus.parity},       exp_par);
    endtask

    // Active edge is falling; inputs change and outputs are sampled on the rising edge.
    task automatic tick();
        @(negedge clk);
        model_edge();
        @(posedge clk);
        check_all();
    endtask

    int feed[8]    = '{1, 0, 1, 0, 0, 1, 0, 1};
    int exp_ser[8] = '{0, 0, 1, 0, 1, 1, 0, 1};

    initial begin
        drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        chk("reset_q", {24'd0, bus.q}, 32'h00);

        drive(1'b1, 3'd3, 8'hA5, 1'b0, 1'b0, 1'b0);
        tick();
        chk("load_a5", {24'd0, bus.q}, 32'hA5);
`ifdef USR_PARITY_EN
        chk("parity_a5", {31'd0, bus.parity}, 32'd0);
`endif

        drive(1'b1, 3'd3, 8'h81, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 3'd4, 8'h00, 1'b0, 1'b0, 1'b0); tick();
        chk("rotr", {24'd0, bus.q}, 32'hC0);
        drive(1'b1, 3'd5, 8'h00, 1'b0, 1'b0, 1'b0); tick();
        chk("rotl", {24'd0, bus.q}, 32'h81);
        drive(1'b1, 3'd2, 8'h00, 1'b0, 1'b0, 1'b0); tick();
        chk("shl", {24'd0, bus.q}, 32'h02);

        drive(1'b1, 3'd3, 8'hFF, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 3'd6, 8'h00, 1'b0, 1'b0, 1'b0); tick();
        chk("cnt_up_wrap", {24'd0, bus.q}, 32'h00);
        drive(1'b1, 3'd7, 8'h00, 1'b0, 1'b0, 1'b0); tick();
        chk("cnt_dn_wrap", {24'd0, bus.q}, 32'hFF);

        // Serial transfer; start wins over a simultaneous load request.
        drive(1'b1, 3'd3, 8'hB4, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 3'd3, 8'h00, 1'b0, 1'b0, 1'b1); tick();
        chk("start_hold_q", {24'd0, bus.q}, 32'hB4);
        for (int i = 0; i < 8; i++) begin
            chk("xfer_ser_out", {31'd0, bus.ser_out}, exp_ser[i]);
            chk("xfer_busy", {31'd0, bus.busy}, 32'd1);
            drive(1'b1, 3'd3, 8'h00, feed[i][0], 1'b0, (i == 3));
            tick();
        end
        chk("xfer_q", {24'd0, bus.q}, 32'hA5);
        chk("xfer_done", {31'd0, bus.done}, 32'd1);
        chk("xfer_cnt", {28'd0, bus.bit_cnt}, 32'd8);
        drive(1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0); tick();
        chk("done_pulse_end", {31'd0, bus.done}, 32'd0);
        chk("cnt_held", {28'd0, bus.bit_cnt}, 32'd8);
        chk("no_retrigger", {31'd0, bus.busy}, 32'd0);

        // Abort after three shifts.
        drive(1'b1, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1); tick();
        drive(1'b1, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0);
        tick(); tick(); tick();
        chk("abort_cnt_pre", {28'd0, bus.bit_cnt}, 32'd3);
        drive(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0); tick();
        chk("abort_q", {24'd0, bus.q}, 32'h00);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_cnt", {28'd0, bus.bit_cnt}, 32'd0);
        drive(1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0); tick();
        chk("abort_no_done", {31'd0, bus.done}, 32'd0);

        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 39) != 0), 3'($urandom_range(0, 7)), W'($urandom),
                  1'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
